// File: rtl/opo_package.sv
// opo_package: shared sweep state encoding and default widths for the sweep analyzer
package opo_package;
  localparam int DEFAULT_WORD_WIDTH   = 16;
  localparam int DEFAULT_PERIOD_WIDTH = 32;
  localparam int DEFAULT_RESET_CYCLES = 100;
  typedef enum logic [2:0] {IDLE, GEN_RESET, SETTLE, MEASURE, REPORT, NEXT, FINISH} sweep_state_t;
endpackage

// File: rtl/peak_tracker.sv
// peak_tracker: running signed min/max of one channel, cleared between sweep points
module peak_tracker #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                en,
  input  logic signed [W-1:0] data,
  input  logic                valid,
  output logic signed [W-1:0] min,
  output logic signed [W-1:0] max,
  output logic                seen
);
  logic signed [W-1:0] min_q, min_d, max_q, max_d;
  logic                seen_q, seen_d, upd;
  always_comb begin
    upd    = en && valid;
    min_d  = clear ? '0 : (upd && (!seen_q || data < min_q)) ? data : min_q;
    max_d  = clear ? '0 : (upd && (!seen_q || data > max_q)) ? data : max_q;
    seen_d = clear ? 1'b0 : seen_q || upd;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q  <= '0;
      max_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      min_q  <= min_d;
      max_q  <= max_d;
      seen_q <= seen_d;
    end
  end
  assign min  = min_q;
  assign max  = max_q;
  assign seen = seen_q;
endmodule

// File: rtl/freq_sweep_analyzer.sv
// freq_sweep_analyzer: steps sine_gen period over a range and streams per-channel min/max/p2p per point
module freq_sweep_analyzer
  import opo_package::*;
#(
  parameter int WORD_WIDTH   = DEFAULT_WORD_WIDTH,
  parameter int NUM_CH       = 10,
  parameter int PERIOD_WIDTH = DEFAULT_PERIOD_WIDTH,
  parameter int CNT_WIDTH    = 32,
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [PERIOD_WIDTH-1:0]        period_start,
  input  logic [PERIOD_WIDTH-1:0]        period_step,
  input  logic [PERIOD_WIDTH-1:0]        period_stop,
  input  logic [CNT_WIDTH-1:0]           settle_cycles,
  input  logic [CNT_WIDTH-1:0]           window_cycles,
  input  logic [NUM_CH*WORD_WIDTH-1:0]   ch_data,
  input  logic [NUM_CH-1:0]              ch_valid,
  output logic [PERIOD_WIDTH-1:0]        period_out,
  output logic                           gen_rst,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [PERIOD_WIDTH-1:0]        res_period,
  output logic [$clog2(NUM_CH)-1:0]      res_channel,
  output logic signed [WORD_WIDTH-1:0]   res_min,
  output logic signed [WORD_WIDTH-1:0]   res_max,
  output logic [WORD_WIDTH:0]            res_p2p,
  output logic                           res_empty,
  output logic                           busy,
  output logic                           done
);
  localparam int CH_W = $clog2(NUM_CH);
  sweep_state_t                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0]       period_q, period_d, step_q, step_d, stop_q, stop_d;
  logic [CNT_WIDTH-1:0]          settle_q, settle_d, window_q, window_d, cnt_q, cnt_d, win_last;
  logic [CH_W-1:0]               ch_q, ch_d;
  logic [PERIOD_WIDTH:0]         sum;
  logic signed [WORD_WIDTH-1:0]  mins [NUM_CH];
  logic signed [WORD_WIDTH-1:0]  maxs [NUM_CH];
  logic [NUM_CH-1:0]             seen;
  logic                          show;
  assign sum      = {1'b0, period_q} + {1'b0, step_q};
  assign win_last = (window_q == '0) ? '0 : window_q - 1'b1;
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    step_d   = step_q;
    stop_d   = stop_q;
    settle_d = settle_q;
    window_d = window_q;
    ch_d     = ch_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = GEN_RESET;
        period_d = period_start;
        step_d   = period_step;
        stop_d   = period_stop;
        settle_d = settle_cycles;
        window_d = window_cycles;
      end
      GEN_RESET: if (cnt_q == CNT_WIDTH'(RESET_CYCLES - 1)) state_d = (settle_q == '0) ? MEASURE : SETTLE;
      SETTLE:    if (cnt_q == settle_q - 1'b1) state_d = MEASURE;
      MEASURE: if (cnt_q == win_last) begin
        state_d = REPORT;
        ch_d    = '0;
      end
      REPORT: if (res_ready) begin
        state_d = (ch_q == CH_W'(NUM_CH - 1)) ? NEXT : REPORT;
        ch_d    = (ch_q == CH_W'(NUM_CH - 1)) ? ch_q : ch_q + 1'b1;
      end
      NEXT: if (step_q == '0 || sum[PERIOD_WIDTH] || sum[PERIOD_WIDTH-1:0] > stop_q) begin
        state_d = FINISH;
      end else begin
        state_d  = GEN_RESET;
        period_d = sum[PERIOD_WIDTH-1:0];
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
    cnt_d = (state_d == state_q) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      step_q   <= '0;
      stop_q   <= '0;
      settle_q <= '0;
      window_q <= '0;
      cnt_q    <= '0;
      ch_q     <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      step_q   <= step_d;
      stop_q   <= stop_d;
      settle_q <= settle_d;
      window_q <= window_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
    end
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_trk
    peak_tracker #(.W(WORD_WIDTH)) u_trk (
      .clk   (clk),
      .rst   (rst),
      .clear (state_q == GEN_RESET),
      .en    (state_q == MEASURE),
      .data  (ch_data[k*WORD_WIDTH +: WORD_WIDTH]),
      .valid (ch_valid[k]),
      .min   (mins[k]),
      .max   (maxs[k]),
      .seen  (seen[k])
    );
  end
  // Result fields read as zero outside REPORT and for channels that saw no sample.
  assign show        = (state_q == REPORT) && seen[ch_q];
  assign res_valid   = state_q == REPORT;
  assign res_empty   = res_valid && !seen[ch_q];
  assign res_min     = show ? mins[ch_q] : '0;
  assign res_max     = show ? maxs[ch_q] : '0;
  assign res_p2p     = show ? {maxs[ch_q][WORD_WIDTH-1], maxs[ch_q]} - {mins[ch_q][WORD_WIDTH-1], mins[ch_q]} : '0;
  assign res_period  = period_q;
  assign res_channel = ch_q;
  assign period_out  = period_q;
  assign gen_rst     = !(state_q == SETTLE || state_q == MEASURE);
  assign busy        = state_q != IDLE;
  assign done        = state_q == FINISH;
endmodule

// File: tb/tb_freq_sweep_analyzer.sv
// tb_freq_sweep_analyzer: table-driven sweeps checked cycle by cycle against a timeline/min-max model
module tb_freq_sweep_analyzer;
  localparam int W = 16, N = 2, PW = 32, CWD = 32, R = 100;
  logic                  clk = 1'b0;
  logic                  rst, start, abort, res_ready;
  logic [PW-1:0]         period_start, period_step, period_stop;
  logic [CWD-1:0]        settle_cycles, window_cycles;
  logic [N*W-1:0]        ch_data;
  logic [N-1:0]          ch_valid;
  logic [PW-1:0]         period_out, res_period;
  logic                  gen_rst, res_valid, res_empty, busy, done;
  logic [$clog2(N)-1:0]  res_channel;
  logic signed [W-1:0]   res_min, res_max;
  logic [W:0]            res_p2p;
  int errors = 0, checks = 0;

  freq_sweep_analyzer #(.WORD_WIDTH(W), .NUM_CH(N), .PERIOD_WIDTH(PW), .CNT_WIDTH(CWD), .RESET_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .period_start(period_start), .period_step(period_step), .period_stop(period_stop),
    .settle_cycles(settle_cycles), .window_cycles(window_cycles),
    .ch_data(ch_data), .ch_valid(ch_valid),
    .period_out(period_out), .gen_rst(gen_rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_period(res_period), .res_channel(res_channel), .res_min(res_min), .res_max(res_max),
    .res_p2p(res_p2p), .res_empty(res_empty), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] ps, st, sp;
    int            settle, win, rdy;
    logic [N-1:0]  mask;
    int            mode, pts;
    bit            chk0;
    int            emin, emax, ep2p;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [W-1:0] u(input int v);
    return v[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_gen_rst"}, gen_rst, 1);
    chk({tag, "_period_out"}, period_out, 0);
    chk({tag, "_res_period"}, res_period, 0);
    chk({tag, "_res_channel"}, res_channel, 0);
    chk({tag, "_res_min"}, $unsigned(res_min), 0);
    chk({tag, "_res_max"}, $unsigned(res_max), 0);
    chk({tag, "_res_p2p"}, res_p2p, 0);
    chk({tag, "_res_empty"}, res_empty, 0);
  endtask

  // mode 0: random samples; 1: ch0 ramps -20 upward; 2: ch0 alternates full-scale extremes
  task automatic drive_data(input int mode, input int k, input logic [N-1:0] mask);
    for (int c = 0; c < N; c++) begin
      ch_data[c*W +: W] = W'($urandom);
      ch_valid[c] = mask[c] & 1'($urandom);
    end
    if (mode == 1) begin
      ch_data[W-1:0] = u(k - 20);
      ch_valid[0] = 1'b1;
    end
    if (mode == 2) begin
      ch_data[W-1:0] = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
      ch_valid[0] = 1'b1;
    end
  endtask

  task automatic kick(input logic [PW-1:0] ps, st, sp, input int settle, win);
    tick();
    period_start = ps;
    period_step = st;
    period_stop = sp;
    settle_cycles = settle;
    window_cycles = win;
    start = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_gen_rst", gen_rst, 1);
    tick();
    start = 1'b0;
    period_start = '1;
    period_step = '0;
    period_stop = '0;
    settle_cycles = 7;
    window_cycles = 2;
  endtask

  task automatic run_vec(input vec_t v);
    logic [PW-1:0] p;
    logic [PW:0]   s;
    logic [W-1:0]  c_min, c_max;
    logic [W:0]    c_p2p, e_p2p;
    int            q[N][$];
    int            mn, mx, win, guard;
    bit            hs;
    c_min = '0;
    c_max = '0;
    c_p2p = '0;
    win = (v.win == 0) ? 1 : v.win;
    kick(v.ps, v.st, v.sp, v.settle, v.win);
    p = v.ps;
    for (int pt = 0; pt < v.pts; pt++) begin
      for (int i = 0; i < R; i++) begin
        start = 1'($urandom);
        @(negedge clk);
        chk("reset_gen_rst", gen_rst, 1);
        chk("reset_period", period_out, p);
        chk("reset_res_valid", res_valid, 0);
        tick();
      end
      start = 1'b0;
      for (int i = 0; i < v.settle; i++) begin
        @(negedge clk);
        chk("settle_gen_rst", gen_rst, 0);
        chk("settle_busy", busy, 1);
        tick();
      end
      for (int c = 0; c < N; c++) q[c].delete();
      for (int k = 0; k < win; k++) begin
        drive_data(v.mode, k, v.mask);
        for (int c = 0; c < N; c++)
          if (ch_valid[c]) q[c].push_back(int'($signed(ch_data[c*W +: W])));
        @(negedge clk);
        chk("measure_gen_rst", gen_rst, 0);
        chk("measure_res_valid", res_valid, 0);
        tick();
      end
      ch_valid = '0;
      for (int c = 0; c < N; c++) begin
        mn = 0;
        mx = 0;
        for (int j = 0; j < q[c].size(); j++) begin
          if (j == 0 || q[c][j] < mn) mn = q[c][j];
          if (j == 0 || q[c][j] > mx) mx = q[c][j];
        end
        e_p2p = (W+1)'(mx - mn);
        guard = 0;
        hs = 1'b0;
        while (!hs) begin
          res_ready = (guard > 20) || ($urandom_range(99) < v.rdy);
          hs = res_ready;
          @(negedge clk);
          chk("rep_valid", res_valid, 1);
          chk("rep_gen_rst", gen_rst, 1);
          chk("rep_period", res_period, p);
          chk("rep_channel", res_channel, c);
          chk("rep_empty", res_empty, q[c].size() == 0);
          chk("rep_min", $unsigned(res_min), u(mn));
          chk("rep_max", $unsigned(res_max), u(mx));
          chk("rep_p2p", res_p2p, e_p2p);
          if (c == 0) begin
            c_min = res_min;
            c_max = res_max;
            c_p2p = res_p2p;
          end
          tick();
          guard++;
        end
      end
      res_ready = 1'b0;
      @(negedge clk);
      chk("next_res_valid", res_valid, 0);
      chk("next_done", done, 0);
      chk("next_busy", busy, 1);
      chk("next_gen_rst", gen_rst, 1);
      tick();
      s = {1'b0, p} + {1'b0, v.st};
      p = s[PW-1:0];
    end
    start = 1'b1;
    @(negedge clk);
    chk("finish_done", done, 1);
    chk("finish_res_valid", res_valid, 0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    if (v.chk0) begin
      chk("ch0_min", c_min, u(v.emin));
      chk("ch0_max", c_max, u(v.emax));
      chk("ch0_p2p", c_p2p, (W+1)'(v.ep2p));
    end
  endtask

  initial begin
    vecs[0] = '{ps: 10, st: 5, sp: 10, settle: 0, win: 40, rdy: 100, mask: 2'b11, mode: 1, pts: 1,
                chk0: 1, emin: -20, emax: 19, ep2p: 39};
    vecs[1] = '{ps: 2, st: 5, sp: 17, settle: 3, win: 20, rdy: 100, mask: 2'b11, mode: 0, pts: 4,
                chk0: 0, emin: 0, emax: 0, ep2p: 0};
    vecs[2] = '{ps: 100, st: 1, sp: 102, settle: 5, win: 15, rdy: 40, mask: 2'b11, mode: 0, pts: 3,
                chk0: 0, emin: 0, emax: 0, ep2p: 0};
    vecs[3] = '{ps: 7, st: 0, sp: 50, settle: 2, win: 10, rdy: 70, mask: 2'b01, mode: 0, pts: 1,
                chk0: 0, emin: 0, emax: 0, ep2p: 0};
    vecs[4] = '{ps: 32'hFFFF_FFFE, st: 5, sp: 32'hFFFF_FFFF, settle: 0, win: 4, rdy: 60, mask: 2'b11, mode: 2,
                pts: 1, chk0: 1, emin: -32768, emax: 32767, ep2p: 65535};
    vecs[5] = '{ps: 50, st: 3, sp: 20, settle: 1, win: 0, rdy: 50, mask: 2'b11, mode: 0, pts: 1,
                chk0: 0, emin: 0, emax: 0, ep2p: 0};
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    res_ready = 1'b0;
    period_start = '0;
    period_step = '0;
    period_stop = '0;
    settle_cycles = '0;
    window_cycles = '0;
    ch_data = '0;
    ch_valid = '0;
    tick();
    @(negedge clk);
    check_reset("por");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    kick(5, 1, 9, 2, 30);
    repeat (R + 2 + 5) tick();
    @(negedge clk);
    chk("abort_pre_gen_rst", gen_rst, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_gen_rst", gen_rst, 1);
    for (int i = 0; i < 4; i++) begin
      chk("abort_done", done, 0);
      tick();
    end
    kick(3, 1, 3, 0, 3);
    repeat (R + 3) tick();
    @(negedge clk);
    chk("abort_rep_pre_valid", res_valid, 1);
    res_ready = 1'b1;
    abort = 1'b1;
    tick();
    res_ready = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_rep_busy", busy, 0);
    chk("abort_rep_res_valid", res_valid, 0);
    chk("abort_rep_gen_rst", gen_rst, 1);
    chk("abort_rep_done", done, 0);
    kick(3, 1, 3, 0, 3);
    repeat (R + 3) tick();
    @(negedge clk);
    chk("rst_pre_valid", res_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset("rst_mid");
    run_vec(vecs[1]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
